// File: rtl/vram_arbiter.sv
// Single-port video RAM sequencer: display reads > clear-screen engine > buffered writes.
// Optional statistics outputs (drop_cnt, max_wait) are enabled by defining VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned NPIX       = 19200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk16M,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              cls_start,
  input  logic [DATA_W-1:0] cls_color,
  output logic              cls_busy,
  output logic              cls_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [7:0]        max_wait
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic                wr_full_q;
  logic                rd1_q, rd2_q, disp_valid_q;
  logic [DATA_W-1:0]   disp_data_q;
  logic                push, pop;

  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];

  assign push = wr_req && (count_q != FULL_CNT);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: if (cls_start) begin
        state_d     = S_CLEAR;
        clr_color_d = cls_color;
        clr_cnt_d   = '0;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // Pops only see entries already stored; a same-cycle push lands behind them.
    if (disp_req) begin
      mem_addr_d = disp_addr;
    end else if (state_q == S_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_cnt_q;
      mem_wdata_d = clr_color_q;
      if (clr_cnt_q == LAST_PIX) state_d = S_DONE;
      else                       clr_cnt_d = clr_cnt_q + 1'b1;
    end else if (count_q != '0) begin
      pop         = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_addr[rptr_q];
      mem_wdata_d = fifo_data[rptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      wr_full_q    <= 1'b0;
      rd1_q        <= 1'b0;
      rd2_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      count_q      <= count_d;
      wr_full_q    <= (count_d == FULL_CNT);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      rd1_q        <= disp_req;
      rd2_q        <= rd1_q;
      disp_valid_q <= rd2_q;
      if (rd2_q) disp_data_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk16M) begin
    if (push) begin
      fifo_addr[wptr_q] <= wr_addr;
      fifo_data[wptr_q] <= wr_data;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_full    = wr_full_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign cls_busy   = (state_q == S_CLEAR);
  assign cls_done   = (state_q == S_DONE);

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [7:0]  head_wait_q, max_wait_q;

  // head_wait_q counts cycles the current head has been waiting; it restarts on every pop.
  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      drop_cnt_q  <= '0;
      head_wait_q <= '0;
      max_wait_q  <= '0;
    end else begin
      if (wr_req && wr_full_q && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (pop) begin
        if (head_wait_q > max_wait_q) max_wait_q <= head_wait_q;
        head_wait_q <= '0;
      end else if ((count_q != '0) && (head_wait_q != '1)) begin
        head_wait_q <= head_wait_q + 8'd1;
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign max_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: queue-based reference model, per-cycle compare,
// plus directed literal checks for reads, FIFO fill/drain, clears and reset abort.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 6;
  localparam int NPIX = 19200;
  localparam int DEPTH = 4;

  logic          clk16M = 1'b0;
  logic          rst = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_full;
  logic          cls_start = 1'b0;
  logic [DW-1:0] cls_color = '0;
  logic          cls_busy;
  logic          cls_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NPIX(NPIX), .FIFO_DEPTH(DEPTH)) dut (
    .clk16M(clk16M), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .cls_start(cls_start), .cls_color(cls_color), .cls_busy(cls_busy), .cls_done(cls_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk16M = ~clk16M;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_pix(input int i);
    if (i == 5) return 6'h2A;
    return DW'((i * 7 + 3) % 64);
  endfunction

  // Synchronous RAM with one cycle of read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = init_pix(i);
    forever begin
      @(posedge clk16M);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  // Reference model: FIFO as a queue, clear as a counter, reads as a due-time queue.
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t           fq[$];
  int            rd_due[$];
  logic [DW-1:0] rd_val[$];
  logic [DW-1:0] gold [0:(1<<AW)-1];
  int            mode;
  int            clr_next;
  logic [DW-1:0] clr_color_m;
  int            cyc;
  logic          e_we, e_valid, e_full, e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ddata;

  task automatic model_reset();
    fq.delete(); rd_due.delete(); rd_val.delete();
    mode = 0; clr_next = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_valid = 1'b0; e_ddata = '0;
    e_full = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_step();
    int  old_mode;
    int  old_size;
    wr_t w;
    old_mode = mode;
    old_size = fq.size();
    cyc++;
    e_valid = 1'b0;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      e_valid = 1'b1;
      e_ddata = rd_val.pop_front();
      void'(rd_due.pop_front());
    end
    e_we = 1'b0;
    if (disp_req) begin
      e_addr = disp_addr;
      rd_due.push_back(cyc + 2);
      rd_val.push_back(gold[disp_addr]);
    end else if (old_mode == 1) begin
      e_we = 1'b1; e_addr = AW'(clr_next); e_wdata = clr_color_m;
      gold[clr_next] = clr_color_m;
      if (clr_next == NPIX - 1) mode = 2;
      else clr_next++;
    end else if (old_size > 0) begin
      w = fq.pop_front();
      e_we = 1'b1; e_addr = w.a; e_wdata = w.d;
      gold[w.a] = w.d;
    end
    if (old_mode == 2) mode = 0;
    if (old_mode == 0 && cls_start) begin
      mode = 1; clr_next = 0; clr_color_m = cls_color;
    end
    if (wr_req && old_size < DEPTH) begin
      w.a = wr_addr; w.d = wr_data;
      fq.push_back(w);
    end
    e_full = (fq.size() == DEPTH);
    e_busy = (mode == 1);
    e_done = (mode == 2);
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < (1 << AW); i++) gold[i] = init_pix(i);
    model_reset();
    forever begin
      @(posedge clk16M or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk16M);
      if (rst) begin
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), int'(e_addr));
        if (e_we) chk("mem_wdata", int'(mem_wdata), int'(e_wdata));
        chk("disp_valid", int'(disp_valid), int'(e_valid));
        chk("disp_data", int'(disp_data), int'(e_ddata));
        chk("wr_full", int'(wr_full), int'(e_full));
        chk("cls_busy", int'(cls_busy), int'(e_busy));
        chk("cls_done", int'(cls_done), int'(e_done));
      end
    end
  end

  task automatic tick();
    @(posedge clk16M);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_disp_valid"}, int'(disp_valid), 0);
    chk({tag, "_disp_data"}, int'(disp_data), 0);
    chk({tag, "_wr_full"}, int'(wr_full), 0);
    chk({tag, "_cls_busy"}, int'(cls_busy), 0);
    chk({tag, "_cls_done"}, int'(cls_done), 0);
  endtask

  // Runs a clear until cls_done, tallying written addresses/colours; alt=1 interleaves reads.
  task automatic run_clear(input logic [DW-1:0] color, input bit alt, output int n, output int bad, output bit done_seen);
    n = 0; bad = 0; done_seen = 1'b0;
    for (int c = 0; c < 45000 && !done_seen; c++) begin
      disp_req  = alt && (c % 2 == 0);
      disp_addr = AW'($urandom_range(0, NPIX - 1));
      wr_req    = alt && (c == 50);
      wr_addr   = AW'(7);
      wr_data   = 6'h05;
      cls_start = alt && (c == 100);
      cls_color = 6'h01;
      tick();
      if (cls_done) done_seen = 1'b1;
      else if (!cls_busy) bad++;
      if (mem_we) begin
        if (int'(mem_addr) != n) bad++;
        if (mem_wdata != color) bad++;
        n++;
      end
    end
    disp_req = 1'b0; wr_req = 1'b0; cls_start = 1'b0;
  endtask

  initial begin
    int  n, bad;
    bit  done_seen, found;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;

    // Single read of a preloaded pixel.
    disp_req = 1'b1; disp_addr = AW'(5);
    tick();
    disp_req = 1'b0;
    chk("rd_addr", int'(mem_addr), 5);
    chk("rd_we", int'(mem_we), 0);
    chk("rd_valid_k1", int'(disp_valid), 0);
    tick();
    chk("rd_valid_k2", int'(disp_valid), 0);
    tick();
    chk("rd_valid_k3", int'(disp_valid), 1);
    chk("rd_data", int'(disp_data), 'h2A);

    // Fill the FIFO under continuous display reads, then drain.
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = AW'(i + 1); wr_data = DW'(8'h11 + i);
      disp_addr = AW'($urandom_range(0, NPIX - 1));
      tick();
      if (i == 3) chk("fifo_full_after4", int'(wr_full), 1);
    end
    wr_req = 1'b0;
    chk("fifo_full_after5", int'(wr_full), 1);
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", int'(mem_we), 1);
      chk("drain_addr", int'(mem_addr), i + 1);
      chk("drain_data", int'(mem_wdata), 'h11 + i);
    end
    chk("drain_not_full", int'(wr_full), 0);
    tick();
    chk("fifth_dropped", int'(mem_we), 0);

    // Clear with no display traffic.
    cls_start = 1'b1; cls_color = 6'h3F;
    tick();
    cls_start = 1'b0;
    chk("clr_busy_start", int'(cls_busy), 1);
    run_clear(6'h3F, 1'b0, n, bad, done_seen);
    chk("clr_done_seen", int'(done_seen), 1);
    chk("clr_writes", n, NPIX);
    chk("clr_seq_bad", bad, 0);
    tick();
    chk("clr_done_pulse", int'(cls_done), 0);
    chk("clr_busy_end", int'(cls_busy), 0);

    // Clear interleaved with reads, a buffered write to pixel 7 and an ignored cls_start.
    cls_start = 1'b1; cls_color = 6'h15;
    tick();
    cls_start = 1'b0;
    run_clear(6'h15, 1'b1, n, bad, done_seen);
    chk("alt_done_seen", int'(done_seen), 1);
    chk("alt_writes", n, NPIX);
    chk("alt_seq_bad", bad, 0);
    tick();
    chk("post_clr_we", int'(mem_we), 1);
    chk("post_clr_addr", int'(mem_addr), 7);
    repeat (3) tick();
    chk("ram7_final", int'(ram[7]), 5);

    // Random traffic checked by the model.
    for (int c = 0; c < 2000; c++) begin
      disp_req  = ($urandom_range(0, 1) == 1);
      disp_addr = AW'($urandom_range(0, (1 << AW) - 1));
      wr_req    = ($urandom_range(0, 9) < 6);
      wr_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      wr_data   = DW'($urandom_range(0, 63));
      tick();
    end
    disp_req = 1'b0; wr_req = 1'b0;
    repeat (8) tick();

    // Asynchronous reset in the middle of a clear, with a write still buffered.
    cls_start = 1'b1; cls_color = 6'h2C;
    tick();
    cls_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      wr_req = (c == 10); wr_addr = AW'(9); wr_data = 6'h01;
      tick();
      if (mem_we && int'(mem_addr) == 100) found = 1'b1;
    end
    wr_req = 1'b0;
    chk("abort_addr100_seen", int'(found), 1);
    #3 rst = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) tick();
    chk("abort_no_done", int'(cls_done), 0);
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_fifo_lost", int'(mem_we), 0);
    end
    cls_start = 1'b1; cls_color = 6'h0A;
    tick();
    cls_start = 1'b0;
    tick();
    chk("restart_we", int'(mem_we), 1);
    chk("restart_addr0", int'(mem_addr), 0);
    tick();
    chk("restart_addr1", int'(mem_addr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequencer and arbiter for the single-port video RAM between the VGA scan-out and the drawing logic driven by the bt/sw inputs.
- Serves three requesters, highest priority first: display read port, clear-screen engine, buffered write port.
- The display never stalls. Writes are queued in a small FIFO and drain in idle slots, normally during blanking.
- Sits between the VGA timing/pixel path (rgb/hs/vs) and a synchronous RAM with 1-cycle read latency.

Parameters:
- ADDR_W, 15, pixel address width.
- DATA_W, 6, pixel width (matches rgb[5:0]).
- NPIX, 19200, number of framebuffer locations cleared (160x120).
- FIFO_DEPTH, 4, write-buffer entries (power of two).

Ports:
- clk16M  in  1  system clock, 16 MHz.
- rst  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request, one per cycle allowed.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  read pixel.
- disp_valid  out  1  disp_data valid strobe.
- wr_req  in  1  write push request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- wr_full  out  1  FIFO full; pushes are ignored while high.
- cls_start  in  1  clear-screen start pulse.
- cls_color  in  DATA_W  clear colour, sampled together with cls_start.
- cls_busy  out  1  clear in progress.
- cls_done  out  1  one-cycle pulse when the clear finishes.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, clear counter 0. Release is synchronous to clk16M.
- Slot decision on every edge, registered onto mem_*:
  - If disp_req=1: read. mem_we=0, mem_addr=disp_addr.
  - Else if FSM=CLEAR: clear write. mem_we=1, mem_addr=clr_cnt, mem_wdata=clr_color.
  - Else if the FIFO is non-empty: pop the head and write it.
  - Else: mem_we=0, mem_addr holds its last value.
- Read latency: disp_req is sampled at edge k, mem_addr is updated at k, RAM data arrives after k+1, disp_data and disp_valid are registered at k+2. The latency is exactly 2 cycles and fully pipelined: back-to-back requests give back-to-back valids. disp_data holds its value when disp_valid=0.
- FIFO:
  - Occupancy count 0..FIFO_DEPTH. wr_full = (count==FIFO_DEPTH), registered.
  - A push is accepted when wr_req=1 and count<FIFO_DEPTH before the edge. A push while full is dropped, even if a pop happens in the same cycle.
  - A pop uses only entries present before the edge; there is no push-to-pop bypass. With an empty FIFO, the push is stored and the earliest write is at the next edge.
  - Same-cycle push and pop: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: cls_start=1 -> CLEAR. clr_color<=cls_color, clr_cnt<=0, cls_busy<=1.
  - CLEAR: each granted clear slot increments clr_cnt. When the write of clr_cnt=NPIX-1 is issued -> DONE. A cycle taken by a display read leaves clr_cnt unchanged. cls_start is ignored. FIFO pushes are still accepted, but nothing pops until the clear ends.
  - DONE: one cycle. cls_done=1, cls_busy=0, then -> IDLE.
- Ordering: FIFO writes issued after cls_done overwrite cleared pixels.
- Reset during CLEAR: the clear is aborted with no cls_done, and the FIFO contents are lost.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0], reset to 0.
  - Increments on every cycle with wr_req=1 and wr_full=1, saturating at 16'hFFFF.
  - Adds output max_wait [7:0]: the longest number of cycles any FIFO head waited between reaching the head and being popped, saturating at 255. It is cleared only by reset.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
- Reset, then disp_req=1 with disp_addr=0x0005 for 1 cycle, RAM preloaded with 0x2A at that address -> disp_valid=1 exactly 2 cycles later with disp_data=0x2A. mem_we stays 0.
- Push 4 writes (addr 1..4, data 0x11..0x14) while disp_req=1 continuously -> wr_full=1 after the 4th push. A 5th push is dropped (drop_cnt=1 with stats enabled). After disp_req drops, 4 consecutive mem_we=1 cycles occur in order, then wr_full=0.
- cls_start with cls_color=0x3F and no display traffic -> exactly 19200 mem_we cycles, addresses 0..19199, cls_busy high throughout, then cls_done for 1 cycle.
- Clear running while disp_req alternates 1/0 -> every disp_req produces a read with 2-cycle disp_valid. The clear finishes after 19200 granted slots with no address skipped or repeated.
- Push (addr 7, data 0x05) during CLEAR -> the pixel is written after cls_done, and the final RAM[7]=0x05.
- Assert rst=0 asynchronously at clear address 100 -> all outputs 0 immediately with no cls_done. The next cls_start restarts from address 0.
